// File: rtl/pacote_riscv.sv
// Shared RV32 constants and types for the front-end stages.
package pacote_riscv;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [XLEN-1:0] HALT_WORD = 32'h0000_0063;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } estado_t;

    // Instruction fetch is word-granular; low address bits are dropped.
    function automatic logic [XLEN-1:0] alinha_palavra(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/unidade_busca_if_id.sv
// IF/ID pipeline register: flush beats stall, stall beats capture.
module registrador_if_id
    import pacote_riscv::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = pacote_riscv::NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out,
    output logic            valid_out
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;

    // A flush leaves the PC field alone so the bubble still points at the last real slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else if (flush) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else if (!stall) begin
            pc_q    <= pc_in;
            instr_q <= instr_in;
            valid_q <= 1'b1;
        end
    end

    assign pc_out    = pc_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/unidade_busca.sv
// Fetch stage: owns the PC, addresses the instruction ROM and fills the IF/ID register.
module unidade_busca
    import pacote_riscv::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] HALT_WORD = pacote_riscv::HALT_WORD,
    parameter logic [XLEN-1:0] NOP_WORD  = pacote_riscv::NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_address,
    input  logic [XLEN-1:0] imem_instruction,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instruction,
    output logic            if_valid,
    output logic            halted,
    output logic            misaligned_error,
    output logic [XLEN-1:0] fetch_count
);

    estado_t         state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_count_q, fetch_count_d;
    logic            halted_q, halted_d;
    logic            misaligned_q, misaligned_d;
    logic            is_halt_word;
    logic            if_hold;
    logic            if_flush;

    assign is_halt_word = (imem_instruction == HALT_WORD);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        halted_d      = halted_q;
        misaligned_d  = misaligned_q;
        if (redirect) begin
            pc_d     = alinha_palavra(redirect_target);
            state_d  = ST_RUN;
            halted_d = 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
        end else if (!stall && state_q == ST_RUN) begin
            fetch_count_d = fetch_count_q + 1'b1;
            // The halt word is still delivered downstream, but the PC parks on it.
            if (is_halt_word) begin
                state_d  = ST_HALTED;
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + XLEN'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
            halted_q      <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            halted_q      <= halted_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // While halted, each non-stalled edge inserts a bubble so the halt word is seen once.
    assign if_hold  = stall | (state_q == ST_HALTED);
    assign if_flush = redirect | ((state_q == ST_HALTED) & ~stall);

    registrador_if_id #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .stall     (if_hold),
        .flush     (if_flush),
        .pc_in     (pc_q),
        .instr_in  (imem_instruction),
        .pc_out    (if_pc),
        .instr_out (if_instruction),
        .valid_out (if_valid)
    );

    assign imem_address     = pc_q;
    assign halted           = halted_q;
    assign misaligned_error = misaligned_q;
    assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed vector table, then random stimulus against a reference model.
module tb_unidade_busca;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_0063;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        halted;
    logic        misaligned_error;
    logic [31:0] fetch_count;

    logic [31:0] rom [0:63];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_instruction = rom[imem_address[7:2]];

    unidade_busca dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .if_pc            (if_pc),
        .if_instruction   (if_instruction),
        .if_valid         (if_valid),
        .halted           (halted),
        .misaligned_error (misaligned_error),
        .fetch_count      (fetch_count)
    );

    typedef struct {
        logic        rst, stl, rdr;
        logic [31:0] tgt;
        logic [31:0] pc, ifpc, instr;
        logic        valid, hlt, mis;
        logic [31:0] cnt;
        logic        chk_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stl, logic rdr, logic [31:0] tgt,
                                logic [31:0] pc, logic [31:0] ifpc, logic [31:0] instr,
                                logic valid, logic hlt, logic mis, logic [31:0] cnt,
                                logic chk_instr);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.tgt = tgt;
        v.pc = pc; v.ifpc = ifpc; v.instr = instr;
        v.valid = valid; v.hlt = hlt; v.mis = mis; v.cnt = cnt;
        v.chk_instr = chk_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive_edge(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt);
        @(negedge clk);
        reset = rst; stall = stl; redirect = rdr; redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    // Reference model state, updated from the fetch rules one edge at a time.
    logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
    logic        m_valid, m_halted, m_mis, m_bubble;

    task automatic model_edge(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt);
        logic [31:0] word;
        if (rst) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_cnt = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0; m_bubble = 1'b0;
        end else if (rdr) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_instr = NOP; m_halted = 1'b0; m_bubble = 1'b0;
            if (tgt % 4 != 0) m_mis = 1'b1;
        end else if (stl) begin
            // everything holds
        end else if (!m_halted) begin
            word = rom[(m_pc / 4) % 64];
            m_ifpc = m_pc; m_instr = word; m_valid = 1'b1; m_cnt = m_cnt + 1;
            if (word == HALT) m_halted = 1'b1;
            else m_pc = m_pc + 4;
        end else begin
            m_valid = 1'b0; m_bubble = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = NOP;
        rom[0] = 32'h0000_1503; rom[1] = 32'h0040_1583; rom[2] = 32'h00b5_0633;
        rom[3] = 32'h0010_0693; rom[4] = 32'h00d6_0633; rom[5] = 32'h0000_0013;
        rom[6] = 32'h0000_0013; rom[7] = 32'h00c0_2423; rom[8] = HALT;

        //          rst stl rdr tgt            pc            ifpc          instr         v  h  m  cnt  ci
        vecs.push_back(mk(1, 0, 0, 32'h0,       32'h00,       32'h00,       NOP,          0, 0, 0, 0,  1));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 0, 0, 32'h0,   32'(4*k),     32'(4*(k-1)), rom[k-1],     1, 0, 0, 32'(k), 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h20,       32'h20,       HALT,         1, 1, 0, 9,  1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h20,       32'h20,       NOP,          0, 1, 0, 9,  0));
        vecs.push_back(mk(0, 0, 1, 32'h0,       32'h00,       32'h20,       NOP,          0, 0, 0, 9,  1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h04,       32'h00,       32'h00001503, 1, 0, 0, 10, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h08,       32'h04,       32'h00401583, 1, 0, 0, 11, 1));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 1, 0, 32'h0,   32'h08,       32'h04,       32'h00401583, 1, 0, 0, 11, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h0C,       32'h08,       32'h00b50633, 1, 0, 0, 12, 1));
        vecs.push_back(mk(0, 1, 1, 32'h4,       32'h04,       32'h08,       NOP,          0, 0, 0, 12, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h08,       32'h04,       32'h00401583, 1, 0, 0, 13, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h0C,       32'h08,       32'h00b50633, 1, 0, 0, 14, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h10,       32'h0C,       32'h00100693, 1, 0, 0, 15, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h14,       32'h10,       32'h00d60633, 1, 0, 0, 16, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h18,       32'h14,       NOP,          1, 0, 0, 17, 1));
        vecs.push_back(mk(0, 0, 1, 32'h1C,      32'h1C,       32'h14,       NOP,          0, 0, 0, 17, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h20,       32'h1C,       32'h00c02423, 1, 0, 0, 18, 1));
        vecs.push_back(mk(0, 0, 1, 32'h0E,      32'h0C,       32'h1C,       NOP,          0, 0, 1, 18, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h10,       32'h0C,       32'h00100693, 1, 0, 1, 19, 1));
        vecs.push_back(mk(0, 0, 1, 32'h0,       32'h00,       32'h0C,       NOP,          0, 0, 1, 19, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,       32'h00,       32'h0C,       NOP,          0, 0, 1, 19, 1));
        vecs.push_back(mk(1, 0, 1, 32'h2E,      32'h00,       32'h00,       NOP,          0, 0, 0, 0,  1));
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC,32'hFFFFFFFC, 32'h00,       NOP,          0, 0, 0, 0,  1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h00,       32'hFFFFFFFC, NOP,          1, 0, 0, 1,  1));
        vecs.push_back(mk(0, 0, 0, 32'h0,       32'h04,       32'h00,       32'h00001503, 1, 0, 0, 2,  1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive_edge(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].tgt);
            $display("vec %0d: rst=%0b stall=%0b redir=%0b tgt=%08h -> pc=%08h if_pc=%08h instr=%08h v=%0b h=%0b m=%0b cnt=%0d",
                     i, vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].tgt,
                     imem_address, if_pc, if_instruction, if_valid, halted, misaligned_error, fetch_count);
            chk($sformatf("v%0d_pc", i), imem_address, vecs[i].pc);
            chk($sformatf("v%0d_if_pc", i), if_pc, vecs[i].ifpc);
            if (vecs[i].chk_instr) chk($sformatf("v%0d_if_instr", i), if_instruction, vecs[i].instr);
            chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].hlt));
            chk($sformatf("v%0d_misalign", i), 32'(misaligned_error), 32'(vecs[i].mis));
            chk($sformatf("v%0d_count", i), fetch_count, vecs[i].cnt);
        end

        // Random program with scattered halt words, random stalls/redirects/resets.
        for (int i = 0; i < 64; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
        model_edge(1'b1, 1'b0, 1'b0, 32'h0);
        drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
        for (int n = 0; n < 600; n++) begin
            logic        r_rst, r_stl, r_rdr;
            logic [31:0] r_tgt;
            r_rst = (n == 0) ? 1'b1 : ($urandom_range(0, 63) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_rdr = ($urandom_range(0, 7) == 0);
            r_tgt = 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 7) == 0) r_tgt = r_tgt + 32'($urandom_range(1, 3));
            model_edge(r_rst, r_stl, r_rdr, r_tgt);
            drive_edge(r_rst, r_stl, r_rdr, r_tgt);
            $display("rnd %0d: rst=%0b stall=%0b redir=%0b tgt=%08h -> pc=%08h if_pc=%08h instr=%08h v=%0b h=%0b cnt=%0d",
                     n, r_rst, r_stl, r_rdr, r_tgt, imem_address, if_pc, if_instruction, if_valid, halted, fetch_count);
            chk($sformatf("r%0d_pc", n), imem_address, m_pc);
            chk($sformatf("r%0d_if_pc", n), if_pc, m_ifpc);
            if (!m_bubble) chk($sformatf("r%0d_if_instr", n), if_instruction, m_instr);
            chk($sformatf("r%0d_if_valid", n), 32'(if_valid), 32'(m_valid));
            chk($sformatf("r%0d_halted", n), 32'(halted), 32'(m_halted));
            chk($sformatf("r%0d_misalign", n), 32'(misaligned_error), 32'(m_mis));
            chk($sformatf("r%0d_count", n), fetch_count, m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
